// File: rtl/apb_ucpd_bmc_rx_timing_pkg.sv
// Shared UCPD receive-timing types: FSM state encoding, interval classes and
// default sizing for the BMC interval counter.
package apb_ucpd_pkg;

  localparam int CNT_W_DEF      = 9;
  localparam int IDLE_HBITS_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HALF
  } rx_state_e;

  typedef enum logic [1:0] {
    IV_SHORT,
    IV_LONG,
    IV_GLITCH,
    IV_OVER
  } iv_class_e;

endpackage

// File: rtl/apb_ucpd_bmc_rx_timing_if.sv
// Signal bundle between the UCPD control/CC front end and the BMC receive
// timing recovery block.
interface apb_ucpd_bmc_rx_timing_if;

  logic       ucpd_tick;
  logic       rx_en;
  logic       cc_rx;
  logic [5:0] hbitclkdiv;
  logic       rx_bit;
  logic       rx_bit_vld;
  logic       rx_active;
  logic       rx_idle;
  logic       bmc_err;

  modport slave (
    input  ucpd_tick, rx_en, cc_rx, hbitclkdiv,
    output rx_bit, rx_bit_vld, rx_active, rx_idle, bmc_err
  );

  modport master (
    output ucpd_tick, rx_en, cc_rx, hbitclkdiv,
    input  rx_bit, rx_bit_vld, rx_active, rx_idle, bmc_err
  );

endinterface

// File: rtl/apb_ucpd_bmc_rx_timing_cnt.sv
// CC edge detector plus saturating UCPD tick counter that classifies the
// interval between transitions against half-bit multiples.
module apb_ucpd_rx_interval_cnt
  import apb_ucpd_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int IDLE_HBITS = IDLE_HBITS_DEF
) (
  input  logic       ic_clk,
  input  logic       ic_rst_n,
  input  logic       ucpd_tick,
  input  logic       cc_rx,
  input  logic [5:0] hbitclkdiv,
  output logic       cc_edge,
  output iv_class_e  iv_class,
  output logic       idle_hit
);

  localparam int CW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             cc_d;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       hdiv;
  logic [CW-1:0]    cnt_x, cnt2, hdiv_x, hdiv3, hdiv_idle;

  assign hdiv      = {1'b0, hbitclkdiv} + 7'd1;
  assign cnt_x     = CW'(cnt);
  assign cnt2      = cnt_x << 1;
  assign hdiv_x    = CW'(hdiv);
  assign hdiv3     = hdiv_x * CW'(3);
  assign hdiv_idle = hdiv_x * CW'(IDLE_HBITS);

  assign cc_edge  = cc_d ^ cc_rx;
  assign idle_hit = (cnt_x >= hdiv_idle);

  // Doubled count keeps the 0.5 and 1.5 half-bit thresholds integral
  always_comb begin
    iv_class = IV_OVER;
    if (cnt2 < hdiv_x)      iv_class = IV_GLITCH;
    else if (cnt2 < hdiv3)  iv_class = IV_SHORT;
    else if (cnt_x < hdiv3) iv_class = IV_LONG;
  end

  // The edge cycle's own tick counts toward the next interval
  always_ff @(posedge ic_clk) begin
    if (!ic_rst_n) begin
      cc_d <= 1'b0;
      cnt  <= '0;
    end else begin
      cc_d <= cc_rx;
      if (cc_edge)
        cnt <= ucpd_tick ? CNT_ONE : '0;
      else if (ucpd_tick && (cnt != '1))
        cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/apb_ucpd_bmc_rx_timing.sv
// BMC receive timing recovery: turns CC transition intervals into decoded
// bits, flags malformed intervals and reports end of line activity.
module apb_ucpd_bmc_rx_timing
  import apb_ucpd_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int IDLE_HBITS = IDLE_HBITS_DEF
) (
  input logic                      ic_clk,
  input logic                      ic_rst_n,
  apb_ucpd_bmc_rx_timing_if.slave  bus
);

  logic      cc_edge;
  logic      idle_hit;
  iv_class_e iv_class;
  rx_state_e state;
  logic      rx_bit, rx_bit_vld, rx_active, rx_idle, bmc_err;

  apb_ucpd_rx_interval_cnt #(
    .CNT_W      (CNT_W),
    .IDLE_HBITS (IDLE_HBITS)
  ) u_interval_cnt (
    .ic_clk     (ic_clk),
    .ic_rst_n   (ic_rst_n),
    .ucpd_tick  (bus.ucpd_tick),
    .cc_rx      (bus.cc_rx),
    .hbitclkdiv (bus.hbitclkdiv),
    .cc_edge    (cc_edge),
    .iv_class   (iv_class),
    .idle_hit   (idle_hit)
  );

  always_ff @(posedge ic_clk) begin
    if (!ic_rst_n) begin
      state      <= ST_IDLE;
      rx_bit     <= 1'b0;
      rx_bit_vld <= 1'b0;
      rx_active  <= 1'b0;
      rx_idle    <= 1'b0;
      bmc_err    <= 1'b0;
    end else begin
      rx_bit_vld <= 1'b0;
      rx_idle    <= 1'b0;
      bmc_err    <= 1'b0;
      if (!bus.rx_en) begin
        state     <= ST_IDLE;
        rx_active <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cc_edge) begin
              state     <= ST_ARM;
              rx_active <= 1'b1;
            end
          end
          ST_ARM: begin
            if (cc_edge) begin
              if (iv_class == IV_LONG) begin
                rx_bit     <= 1'b0;
                rx_bit_vld <= 1'b1;
              end else if (iv_class == IV_SHORT) begin
                state <= ST_HALF;
              end else begin
                bmc_err <= 1'b1;
              end
            end else if (idle_hit) begin
              state     <= ST_IDLE;
              rx_active <= 1'b0;
              rx_idle   <= 1'b1;
            end
          end
          ST_HALF: begin
            // Any edge here closes the bit; only a second half-bit is legal
            if (cc_edge) begin
              state <= ST_ARM;
              if (iv_class == IV_SHORT) begin
                rx_bit     <= 1'b1;
                rx_bit_vld <= 1'b1;
              end else begin
                bmc_err <= 1'b1;
              end
            end else if (idle_hit) begin
              state     <= ST_IDLE;
              rx_active <= 1'b0;
              rx_idle   <= 1'b1;
            end
          end
          default: begin
            state     <= ST_IDLE;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_bit     = rx_bit;
  assign bus.rx_bit_vld = rx_bit_vld;
  assign bus.rx_active  = rx_active;
  assign bus.rx_idle    = rx_idle;
  assign bus.bmc_err    = bmc_err;

endmodule
